// File: rtl/ram_cache_ctrl_pkg.sv
// Shared types for ram_cache_ctrl: FSM states, register bundle and its reset value.
// Optional statistics counters are compiled in with RAM_CACHE_CTRL_STAT_EN.
package ram_cache_ctrl_pkg;

    localparam int unsigned ABITS  = 6;
    localparam int unsigned DBITS  = 128;
    localparam int unsigned NBYTES = DBITS / 8;
    localparam int unsigned STATW  = 32;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef struct packed {
        state_e             state;
        logic [ABITS-1:0]   cnt;
        logic [ABITS-1:0]   addr;
        logic               init_done;
        logic               resp_valid;
        logic [DBITS-1:0]   rdata;
        logic               flush_pending;
`ifdef RAM_CACHE_CTRL_STAT_EN
        logic [STATW-1:0]   stat_rd;
        logic [STATW-1:0]   stat_wr;
`endif
    } regs_t;

    localparam regs_t REGS_RST = '{
        state:         INIT,
        cnt:           '0,
        addr:          '0,
        init_done:     1'b0,
        resp_valid:    1'b0,
        rdata:         '0,
        flush_pending: 1'b0
`ifdef RAM_CACHE_CTRL_STAT_EN
        ,
        stat_rd:       '0,
        stat_wr:       '0
`endif
    };

`ifdef RAM_CACHE_CTRL_STAT_EN
    // Saturating increment for the statistics counters.
    function automatic logic [STATW-1:0] sat_inc(input logic [STATW-1:0] v);
        return (v == '1) ? v : v + STATW'(1);
    endfunction
`endif

endpackage

// File: rtl/ram_cache_ctrl_if.sv
// Request/response channel, flush control and RAM port bundle for ram_cache_ctrl.
// slave = controller side, master = requester/RAM side.
interface ram_cache_ctrl_if
    import ram_cache_ctrl_pkg::*;
#(
    parameter int unsigned abits = ABITS,
    parameter int unsigned dbits = DBITS
) ();

    logic                 i_flush;
    logic                 o_init_done;
    logic                 i_req_valid;
    logic                 o_req_ready;
    logic                 i_req_write;
    logic [abits-1:0]     i_req_addr;
    logic [dbits/8-1:0]   i_req_wstrb;
    logic [dbits-1:0]     i_req_wdata;
    logic                 o_resp_valid;
    logic                 i_resp_ready;
    logic [dbits-1:0]     o_resp_rdata;
    logic [abits-1:0]     o_ram_addr;
    logic [dbits/8-1:0]   o_ram_wena;
    logic [dbits-1:0]     o_ram_wdata;
    logic [dbits-1:0]     i_ram_rdata;

    modport slave (
        input  i_flush, i_req_valid, i_req_write, i_req_addr, i_req_wstrb, i_req_wdata,
        input  i_resp_ready, i_ram_rdata,
        output o_init_done, o_req_ready, o_resp_valid, o_resp_rdata,
        output o_ram_addr, o_ram_wena, o_ram_wdata
    );

    modport master (
        output i_flush, i_req_valid, i_req_write, i_req_addr, i_req_wstrb, i_req_wdata,
        output i_resp_ready, i_ram_rdata,
        input  o_init_done, o_req_ready, o_resp_valid, o_resp_rdata,
        input  o_ram_addr, o_ram_wena, o_ram_wdata
    );

endinterface

// File: rtl/ram_cache_ctrl.sv
// Front-end for a byte-write-enabled single-port cache data RAM: accepts
// read/write requests, returns held read responses, and zero-sweeps the
// array after reset and on flush. Define RAM_CACHE_CTRL_STAT_EN for
// saturating accepted-read/write counters.
module ram_cache_ctrl
    import ram_cache_ctrl_pkg::*;
#(
    parameter int unsigned abits = ABITS,
    parameter int unsigned dbits = DBITS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    ram_cache_ctrl_if.slave     bus
`ifdef RAM_CACHE_CTRL_STAT_EN
    ,
    output logic [STATW-1:0]    o_stat_rd,
    output logic [STATW-1:0]    o_stat_wr
`endif
);

    regs_t                r_q;
    regs_t                r_d;
    logic                 req_ready_c;
    logic [abits-1:0]     ram_addr_c;
    logic [dbits/8-1:0]   ram_wena_c;
    logic [dbits-1:0]     ram_wdata_c;

    // State register bundle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= REGS_RST;
        end else begin
            r_q <= r_d;
        end
    end

    // Next-state and RAM port drive.
    always_comb begin
        r_d         = r_q;
        req_ready_c = 1'b0;
        ram_addr_c  = r_q.addr;
        ram_wena_c  = '0;
        ram_wdata_c = '0;

        case (r_q.state)
            INIT: begin
                // Sweep: one zero line per cycle; flush is ignored here.
                ram_addr_c = r_q.cnt;
                ram_wena_c = '1;
                r_d.cnt    = r_q.cnt + ABITS'(1);
                if (r_q.cnt == '1) begin
                    r_d.state     = IDLE;
                    r_d.init_done = 1'b1;
                end
            end
            IDLE: begin
                ram_addr_c = bus.i_req_addr;
                if (bus.i_flush || r_q.flush_pending) begin
                    // Flush wins over a coincident request.
                    r_d.state         = INIT;
                    r_d.cnt           = '0;
                    r_d.init_done     = 1'b0;
                    r_d.flush_pending = 1'b0;
`ifdef RAM_CACHE_CTRL_STAT_EN
                    r_d.stat_rd       = '0;
                    r_d.stat_wr       = '0;
`endif
                end else begin
                    req_ready_c = 1'b1;
                    if (bus.i_req_valid) begin
                        if (bus.i_req_write) begin
                            ram_wena_c  = bus.i_req_wstrb;
                            ram_wdata_c = bus.i_req_wdata;
`ifdef RAM_CACHE_CTRL_STAT_EN
                            r_d.stat_wr = sat_inc(r_q.stat_wr);
`endif
                        end else begin
                            r_d.addr    = bus.i_req_addr;
                            r_d.state   = RD_WAIT;
`ifdef RAM_CACHE_CTRL_STAT_EN
                            r_d.stat_rd = sat_inc(r_q.stat_rd);
`endif
                        end
                    end
                end
            end
            RD_WAIT: begin
                r_d.rdata         = bus.i_ram_rdata;
                r_d.resp_valid    = 1'b1;
                r_d.state         = RESP;
                r_d.flush_pending = r_q.flush_pending | bus.i_flush;
            end
            RESP: begin
                r_d.flush_pending = r_q.flush_pending | bus.i_flush;
                if (bus.i_resp_ready) begin
                    r_d.resp_valid = 1'b0;
                    r_d.state      = IDLE;
                end
            end
            default: begin
                r_d = REGS_RST;
            end
        endcase
    end

    assign bus.o_init_done  = r_q.init_done;
    assign bus.o_resp_valid = r_q.resp_valid;
    assign bus.o_resp_rdata = r_q.rdata;
    assign bus.o_req_ready  = req_ready_c;
    assign bus.o_ram_addr   = ram_addr_c;
    assign bus.o_ram_wena   = ram_wena_c;
    assign bus.o_ram_wdata  = ram_wdata_c;

`ifdef RAM_CACHE_CTRL_STAT_EN
    assign o_stat_rd = r_q.stat_rd;
    assign o_stat_wr = r_q.stat_wr;
`endif

endmodule

// File: tb/tb_ram_cache_ctrl.sv
// Self-checking bench for ram_cache_ctrl: byte-enable RAM on the RAM port,
// array-based reference model of the cache contents, directed + random traffic.
module tb_ram_cache_ctrl;
    import ram_cache_ctrl_pkg::*;

    localparam int unsigned AW    = ABITS;
    localparam int unsigned DW    = DBITS;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_cache_ctrl_if #(.abits(AW), .dbits(DW)) bus ();

`ifdef RAM_CACHE_CTRL_STAT_EN
    logic [31:0] stat_rd;
    logic [31:0] stat_wr;
`endif

    ram_cache_ctrl #(.abits(AW), .dbits(DW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus)
`ifdef RAM_CACHE_CTRL_STAT_EN
        ,
        .o_stat_rd (stat_rd),
        .o_stat_wr (stat_wr)
`endif
    );

    // Byte-enable single-port RAM, 1-cycle synchronous read.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_q;
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(NB); b++) begin
            if (bus.o_ram_wena[b]) ram_mem[bus.o_ram_addr][8*b +: 8] <= bus.o_ram_wdata[8*b +: 8];
        end
        ram_q <= ram_mem[bus.o_ram_addr];
    end
    assign bus.i_ram_rdata = ram_q;

    // Reference model
    logic [DW-1:0] ref_mem [DEPTH];
    int unsigned   ref_rd;
    int unsigned   ref_wr;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        ref_rd = 0;
        ref_wr = 0;
    endtask

    // Counts cycles until o_init_done; 'first' = cycles spent before the sweep begins.
    task automatic wait_init(input int first, input string tag);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            done = bus.o_init_done;
            if (!done && n > first) begin
                check({tag, "_addr"}, DW'(bus.o_ram_addr), DW'(n - first));
                if (n == first + 1) begin
                    check({tag, "_wena"}, DW'(bus.o_ram_wena), DW'({NB{1'b1}}));
                    check({tag, "_wdata"}, bus.o_ram_wdata, '0);
                    check({tag, "_ready"}, DW'(bus.o_req_ready), '0);
                end
            end
        end
        check({tag, "_cycles"}, DW'(n), DW'(64 + first));
    endtask

    // Issue a write; returns cycles waited for ready. Leaves valid asserted.
    task automatic do_write(input logic [AW-1:0] a, input logic [NB-1:0] s,
                            input logic [DW-1:0] d, output int waits);
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b1;
        bus.i_req_addr  = a;
        bus.i_req_wstrb = s;
        bus.i_req_wdata = d;
        waits = 0;
        #1;
        while (!bus.o_req_ready && waits < 40) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            waits++;
        end
        if (!bus.o_req_ready) begin
            check("wr_timeout", DW'(waits), '0);
            bus.i_req_valid = 1'b0;
            return;
        end
        check("wr_wena", DW'(bus.o_ram_wena), DW'(s));
        check("wr_addr", DW'(bus.o_ram_addr), DW'(a));
        @(posedge clk);
        for (int b = 0; b < int'(NB); b++) begin
            if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end
        ref_wr++;
        @(negedge clk);
    endtask

    // Issue a read, hold the response 'hold' cycles (optionally pulsing flush), then consume it.
    task automatic do_read(input logic [AW-1:0] a, input int hold, input bit flush,
                           output logic [DW-1:0] got);
        logic [DW-1:0] expv;
        int waits = 0;
        got = '0;
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b0;
        bus.i_req_addr  = a;
        #1;
        while (!bus.o_req_ready && waits < 40) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            waits++;
        end
        if (!bus.o_req_ready) begin
            check("rd_timeout", DW'(waits), '0);
            bus.i_req_valid = 1'b0;
            return;
        end
        check("rd_wena", DW'(bus.o_ram_wena), '0);
        @(posedge clk);
        expv = ref_mem[a];
        ref_rd++;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        check("rd_lat1", DW'(bus.o_resp_valid), '0);
        @(posedge clk);
        @(negedge clk);
        check("rd_valid", DW'(bus.o_resp_valid), DW'(1));
        check("rd_data", bus.o_resp_rdata, expv);
        got = bus.o_resp_rdata;
        for (int h = 0; h < hold; h++) begin
            bus.i_flush = flush && (h == 0);
            #1;
            check("hold_ready", DW'(bus.o_req_ready), '0);
            @(posedge clk);
            @(negedge clk);
            bus.i_flush = 1'b0;
            check("hold_valid", DW'(bus.o_resp_valid), DW'(1));
            check("hold_data", bus.o_resp_rdata, expv);
        end
        bus.i_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_resp_ready = 1'b0;
        #1;
        check("hs_valid", DW'(bus.o_resp_valid), '0);
        check("hs_ready", DW'(bus.o_req_ready), DW'(!flush));
    endtask

    // Flush pulse from IDLE, optionally coinciding with a pending request.
    task automatic do_flush();
        bus.i_flush = 1'b1;
        #1;
        check("fl_ready", DW'(bus.o_req_ready), '0);
        check("fl_wena", DW'(bus.o_ram_wena), '0);
        @(posedge clk);
        @(negedge clk);
        bus.i_flush     = 1'b0;
        bus.i_req_valid = 1'b0;
        model_clear();
        wait_init(0, "fl");
    endtask

    initial begin
        logic [DW-1:0] got;
        int waits;
        int k;
        bus.i_flush      = 1'b0;
        bus.i_req_valid  = 1'b0;
        bus.i_req_write  = 1'b0;
        bus.i_req_addr   = '0;
        bus.i_req_wstrb  = '0;
        bus.i_req_wdata  = '0;
        bus.i_resp_ready = 1'b0;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_init_done", DW'(bus.o_init_done), '0);
        check("rst_req_ready", DW'(bus.o_req_ready), '0);
        check("rst_resp_valid", DW'(bus.o_resp_valid), '0);
        check("rst_rdata", bus.o_resp_rdata, '0);
        rst = 1'b0;
        check("rel_addr0", DW'(bus.o_ram_addr), '0);
        wait_init(0, "init");

        // Read of the top line after sweep
        do_read(AW'(6'h3F), 0, 1'b0, got);
        check("rd3f_zero", got, '0);

        // Byte-merge write
        do_write(AW'(5), {NB{1'b1}}, {NB{8'hAA}}, waits);
        do_write(AW'(5), NB'(1), {NB{8'h55}}, waits);
        do_read(AW'(5), 0, 1'b0, got);
        check("rd5_merge", got, {{(NB-1){8'hAA}}, 8'h55});

        // Long-held response
        do_read(AW'(5), 10, 1'b0, got);

        // Back-to-back writes to consecutive lines
        for (int i = 0; i < 8; i++) begin
            do_write(AW'(8 + i), NB'($urandom), {$urandom, $urandom, $urandom, $urandom}, waits);
            check("b2b_waits", DW'(waits), '0);
        end
        bus.i_req_valid = 1'b0;
        for (int i = 0; i < 8; i++) do_read(AW'(8 + i), 0, 1'b0, got);

        // Flush while a response is held
        do_read(AW'(5), 3, 1'b1, got);
        check("flresp_data", got, {{(NB-1){8'hAA}}, 8'h55});
        model_clear();
        wait_init(1, "flresp");
        do_read(AW'(5), 0, 1'b0, got);
        check("rd5_flushed", got, '0);

        // Random traffic
        for (int op = 0; op < 250; op++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 48) begin
                logic [NB-1:0] s;
                s = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom);
                do_write(AW'($urandom_range(0, 15)), s, {$urandom, $urandom, $urandom, $urandom}, waits);
            end else if (r < 96) begin
                do_read(AW'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0, got);
            end else begin
                do_flush();
            end
        end
        bus.i_req_valid = 1'b0;
        for (int i = 0; i < 16; i++) do_read(AW'(i), 0, 1'b0, got);

`ifdef RAM_CACHE_CTRL_STAT_EN
        check("stat_rd", DW'(stat_rd), DW'(ref_rd));
        check("stat_wr", DW'(stat_wr), DW'(ref_wr));
`endif

        // Reset in the middle of a sweep
        bus.i_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_flush = 1'b0;
        model_clear();
        k = 0;
        while (bus.o_ram_addr != AW'(20) && k < 100) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("mid_cnt20", DW'(k), DW'(20));
        rst = 1'b1;
        #1;
        check("mid_init_done", DW'(bus.o_init_done), '0);
        check("mid_req_ready", DW'(bus.o_req_ready), '0);
        check("mid_rdata", bus.o_resp_rdata, '0);
        check("mid_addr", DW'(bus.o_ram_addr), '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
`ifdef RAM_CACHE_CTRL_STAT_EN
        check("mid_stat_rd", DW'(stat_rd), '0);
        check("mid_stat_wr", DW'(stat_wr), '0);
`endif
        wait_init(0, "rst2");
        do_read(AW'(5), 0, 1'b0, got);
        check("rd5_after_rst", got, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
